// File: rtl/keypad_scanner.sv
// 4x4 hex keypad scanner: column scan, 2-FF row synchronizer, press/release debounce,
// and a 32-bit shift register of entered digits for the eight-digit display.
module keypad_scanner #(
  parameter int SCAN_DIV   = 1000,
  parameter int DEB_CYCLES = 50000
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [3:0]  Row,
  input  logic        Clear,
  output logic [3:0]  Col,
  output logic [31:0] Value,
  output logic [3:0]  KeyCode,
  output logic        KeyValid
);

  // state    | meaning
  // SCAN     | drive one column per SCAN_DIV clocks, sample rows on the last dwell clock
  // DEBOUNCE | column held, single low row must stay stable DEB_CYCLES clocks
  // HELD     | key accepted, wait for DEB_CYCLES clocks of all rows released
  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD} state_t;

  localparam int DW = $clog2(SCAN_DIV);
  localparam int BW = $clog2(DEB_CYCLES);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [BW-1:0] DEB_LAST   = BW'(DEB_CYCLES - 1);

  state_t        state;
  logic [3:0]    row_meta;
  logic [3:0]    rows;
  logic [3:0]    row_pat;
  logic [1:0]    row_idx;
  logic [1:0]    col_idx;
  logic [DW-1:0] dwell;
  logic [BW-1:0] deb_cnt;

  logic [3:0]    rows_low;
  logic          one_low;
  logic [3:0]    col_next;
  logic [3:0]    accepted_code;

  function automatic logic [1:0] low_index(input logic [3:0] v);
    logic [1:0] idx;
    case (v)
      4'b1110: idx = 2'd0;
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] key_map(input logic [1:0] r, input logic [1:0] c);
    logic [3:0] code;
    case ({r, c})
      4'b00_00: code = 4'h1;
      4'b00_01: code = 4'h2;
      4'b00_10: code = 4'h3;
      4'b00_11: code = 4'hA;
      4'b01_00: code = 4'h4;
      4'b01_01: code = 4'h5;
      4'b01_10: code = 4'h6;
      4'b01_11: code = 4'hB;
      4'b10_00: code = 4'h7;
      4'b10_01: code = 4'h8;
      4'b10_10: code = 4'h9;
      4'b10_11: code = 4'hC;
      4'b11_00: code = 4'h0;
      4'b11_01: code = 4'hF;
      4'b11_10: code = 4'hE;
      4'b11_11: code = 4'hD;
      default:  code = 4'h0;
    endcase
    return code;
  endfunction

  // exactly one row pulled low: the inverted rows form a one-hot vector
  assign rows_low      = ~rows;
  assign one_low       = (rows_low != 4'h0) && ((rows_low & (rows_low - 4'd1)) == 4'h0);
  assign col_next      = {Col[2:0], Col[3]};
  assign accepted_code = key_map(row_idx, col_idx);

  always_ff @(posedge clock) begin
    if (reset) begin
      row_meta <= 4'hF;
      rows     <= 4'hF;
      row_pat  <= 4'hF;
      row_idx  <= 2'd0;
      col_idx  <= 2'd0;
      state    <= SCAN;
      Col      <= 4'b1110;
      dwell    <= '0;
      deb_cnt  <= '0;
      Value    <= 32'h0;
      KeyCode  <= 4'h0;
      KeyValid <= 1'b0;
    end else begin
      row_meta <= Row;
      rows     <= row_meta;
      KeyValid <= 1'b0;
      if (Clear) Value <= 32'h0;

      case (state)
        SCAN: begin
          if (dwell == DWELL_LAST) begin
            dwell <= '0;
            if (one_low) begin
              row_pat <= rows;
              row_idx <= low_index(rows);
              col_idx <= low_index(Col);
              deb_cnt <= '0;
              state   <= DEBOUNCE;
            end else begin
              Col <= col_next;
            end
          end else begin
            dwell <= dwell + DW'(1);
          end
        end

        DEBOUNCE: begin
          if (rows != row_pat) begin
            state <= SCAN;
            Col   <= col_next;
            dwell <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            KeyCode  <= accepted_code;
            // acceptance takes priority over a simultaneous Clear, keeping the new digit
            Value    <= Clear ? {28'h0, accepted_code} : {Value[27:0], accepted_code};
            KeyValid <= 1'b1;
            deb_cnt  <= '0;
            state    <= HELD;
          end else begin
            deb_cnt <= deb_cnt + BW'(1);
          end
        end

        HELD: begin
          if (rows != 4'hF) begin
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= SCAN;
            Col     <= col_next;
            dwell   <= '0;
            deb_cnt <= '0;
          end else begin
            deb_cnt <= deb_cnt + BW'(1);
          end
        end

        default: state <= SCAN;
      endcase
    end
  end

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner with a keypad model that pulls a row low
// only while the pressed key's column is driven low.
module tb_keypad_scanner;

  logic        clock;
  logic        reset;
  logic [3:0]  row_pins;
  logic        Clear;
  logic [3:0]  Col;
  logic [31:0] Value;
  logic [3:0]  KeyCode;
  logic        KeyValid;

  logic        key_on;
  logic        key2_on;
  logic [1:0]  key_r;
  logic [1:0]  key2_r;
  logic [1:0]  key_c;

  int checks;
  int errors;
  int pulses;

  keypad_scanner #(.SCAN_DIV(4), .DEB_CYCLES(8)) dut (
    .clock    (clock),
    .reset    (reset),
    .Row      (row_pins),
    .Clear    (Clear),
    .Col      (Col),
    .Value    (Value),
    .KeyCode  (KeyCode),
    .KeyValid (KeyValid)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    row_pins = 4'hF;
    if (key_on && !Col[key_c])  row_pins[key_r]  = 1'b0;
    if (key2_on && !Col[key_c]) row_pins[key2_r] = 1'b0;
  end

  always @(negedge clock) if (KeyValid) pulses++;

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic press(input logic [1:0] r, input logic [1:0] c);
    key_r  = r;
    key_c  = c;
    key_on = 1'b1;
  endtask

  // holds a key 40 clocks then releases it 40 clocks; reports pulses seen and last code
  task automatic press_key(input logic [1:0] r, input logic [1:0] c,
                           output int n, output logic [3:0] code);
    n    = 0;
    code = 4'h0;
    press(r, c);
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (KeyValid) begin
        n++;
        code = KeyCode;
      end
    end
    key_on = 1'b0;
    tick(40);
  endtask

  function automatic logic [3:0] col_of(input int idx);
    logic [3:0] v;
    v = 4'b0001 << idx;
    return ~v;
  endfunction

  task automatic test_reset;
    logic [3:0] exp_col;
    key_on = 1'b0; key2_on = 1'b0; Clear = 1'b0;
    reset = 1'b1;
    tick(3);
    checks++; if (Col !== 4'b1110) begin errors++; $display("FAIL reset_col: got %b expected 1110", Col); end
    checks++; if (Value !== 32'h0) begin errors++; $display("FAIL reset_value: got %h expected 0", Value); end
    checks++; if (KeyCode !== 4'h0) begin errors++; $display("FAIL reset_keycode: got %h expected 0", KeyCode); end
    checks++; if (KeyValid !== 1'b0) begin errors++; $display("FAIL reset_keyvalid: got %b expected 0", KeyValid); end
    reset = 1'b0;
    for (int k = 0; k < 64; k++) begin
      exp_col = col_of((k / 4) % 4);
      checks++;
      if (Col !== exp_col) begin errors++; $display("FAIL idle_scan_col step %0d: got %b expected %b", k, Col, exp_col); end
      tick(1);
    end
    checks++; if (pulses !== 0) begin errors++; $display("FAIL idle_pulses: got %0d expected 0", pulses); end
    checks++; if (Value !== 32'h0) begin errors++; $display("FAIL idle_value: got %h expected 0", Value); end
  endtask

  task automatic test_single_key;
    int  p0;
    bit  seen;
    bit  held_ok;
    logic [3:0] exp_col;
    p0 = pulses; seen = 0; held_ok = 1;
    press(2'd1, 2'd2);
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (KeyValid) seen = 1;
      if (seen && Col !== 4'b1011) held_ok = 0;
    end
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL key6_pulses: got %0d expected 1", pulses - p0); end
    checks++; if (KeyCode !== 4'h6) begin errors++; $display("FAIL key6_code: got %h expected 6", KeyCode); end
    checks++; if (Value !== 32'h6) begin errors++; $display("FAIL key6_value: got %h expected 00000006", Value); end
    checks++; if (!held_ok) begin errors++; $display("FAIL key6_col_held: got 0 expected 1"); end
    key_on = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      tick(1);
      exp_col = (i <= 9) ? 4'b1011 : 4'b0111;
      checks++;
      if (Col !== exp_col) begin errors++; $display("FAIL key6_release_col step %0d: got %b expected %b", i, Col, exp_col); end
    end
    tick(28);
    checks++; if (pulses - p0 !== 1) begin errors++; $display("FAIL key6_no_repeat: got %0d expected 1", pulses - p0); end
  endtask

  task automatic test_sequence;
    logic [1:0] rs [9] = '{2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd1, 2'd1, 2'd1, 2'd2};
    logic [1:0] cs [9] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    logic [3:0] codes [9] = '{4'h1, 4'h2, 4'h3, 4'hA, 4'h4, 4'h5, 4'h6, 4'hB, 4'h7};
    int p0;
    int n;
    logic [3:0] code;
    p0 = pulses;
    for (int k = 0; k < 9; k++) begin
      press_key(rs[k], cs[k], n, code);
      checks++;
      if (n !== 1 || code !== codes[k]) begin
        errors++; $display("FAIL seq_key %0d: got %0d pulses code %h expected 1 pulse code %h", k, n, code, codes[k]);
      end
      if (k == 7) begin
        checks++; if (Value !== 32'h123A456B) begin errors++; $display("FAIL seq_value8: got %h expected 123a456b", Value); end
      end
    end
    checks++; if (Value !== 32'h23A456B7) begin errors++; $display("FAIL seq_value_wrap: got %h expected 23a456b7", Value); end
    checks++; if (pulses - p0 !== 9) begin errors++; $display("FAIL seq_pulses: got %0d expected 9", pulses - p0); end
  endtask

  task automatic test_bounce;
    int p0;
    int n;
    logic [3:0] code;
    p0 = pulses; n = 0; code = 4'h0;
    press(2'd3, 2'd3);
    tick(3);
    key_on = 1'b0;
    tick(2);
    key_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (KeyValid) begin n++; code = KeyCode; end
    end
    key_on = 1'b0;
    tick(40);
    checks++; if (n !== 1) begin errors++; $display("FAIL bounce_pulses: got %0d expected 1", n); end
    checks++; if (code !== 4'hD) begin errors++; $display("FAIL bounce_code: got %h expected d", code); end
    checks++; if (Value !== 32'h3A456B7D) begin errors++; $display("FAIL bounce_value: got %h expected 3a456b7d", Value); end
    p0 = pulses;
    press(2'd0, 2'd0);
    tick(5);
    key_on = 1'b0;
    tick(40);
    checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL short_press_pulses: got %0d expected 0", pulses - p0); end
    checks++; if (Value !== 32'h3A456B7D) begin errors++; $display("FAIL short_press_value: got %h expected 3a456b7d", Value); end
  endtask

  task automatic test_multi_and_clear;
    int p0;
    int n;
    bit got;
    logic [3:0] code;
    logic [3:0] seen_cols;
    p0 = pulses; seen_cols = 4'h0;
    key_r = 2'd0; key2_r = 2'd2; key_c = 2'd0;
    key_on = 1'b1; key2_on = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      seen_cols = seen_cols | ~Col;
    end
    key_on = 1'b0; key2_on = 1'b0;
    tick(20);
    checks++; if (pulses - p0 !== 0) begin errors++; $display("FAIL multi_pulses: got %0d expected 0", pulses - p0); end
    checks++; if (seen_cols !== 4'hF) begin errors++; $display("FAIL multi_scan: got %b expected 1111", seen_cols); end

    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    press_key(2'd0, 2'd0, n, code);
    press_key(2'd0, 2'd1, n, code);
    checks++; if (Value !== 32'h12) begin errors++; $display("FAIL clear_setup: got %h expected 00000012", Value); end
    Clear = 1'b1;
    tick(1);
    Clear = 1'b0;
    checks++; if (Value !== 32'h0) begin errors++; $display("FAIL clear_value: got %h expected 0", Value); end

    press(2'd0, 2'd2);
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick(1);
      if (KeyValid) got = 1;
    end
    checks++; if (!got) begin errors++; $display("FAIL clear_setup_key3: got timeout expected pulse"); end
    tick(3);
    checks++; if (Value !== 32'h3) begin errors++; $display("FAIL clear_setup_value3: got %h expected 3", Value); end
    key_on = 1'b0;
    for (int i = 1; i <= 35; i++) begin
      tick(1);
      if (i == 11) press(2'd2, 2'd2);
      if (i == 33) Clear = 1'b1;
      if (i == 34) begin
        Clear = 1'b0;
        checks++; if (Value !== 32'h9) begin errors++; $display("FAIL clear_accept_value: got %h expected 00000009", Value); end
        checks++; if (KeyValid !== 1'b1) begin errors++; $display("FAIL clear_accept_valid: got %b expected 1", KeyValid); end
        checks++; if (KeyCode !== 4'h9) begin errors++; $display("FAIL clear_accept_code: got %h expected 9", KeyCode); end
      end
      if (i == 35) begin
        checks++; if (KeyValid !== 1'b0) begin errors++; $display("FAIL clear_accept_pulse_width: got %b expected 0", KeyValid); end
      end
    end
    key_on = 1'b0;
    tick(40);
  endtask

  task automatic test_reset_midflight;
    bit got;
    logic [3:0] exp_col;
    press(2'd1, 2'd1);
    got = 0;
    for (int i = 0; i < 60 && !got; i++) begin
      tick(1);
      if (KeyValid) got = 1;
    end
    checks++; if (!got) begin errors++; $display("FAIL held_setup: got timeout expected pulse"); end
    tick(2);
    reset = 1'b1;
    key_on = 1'b0;
    tick(1);
    checks++; if (Col !== 4'b1110) begin errors++; $display("FAIL held_reset_col: got %b expected 1110", Col); end
    checks++; if (Value !== 32'h0) begin errors++; $display("FAIL held_reset_value: got %h expected 0", Value); end
    checks++; if (KeyValid !== 1'b0) begin errors++; $display("FAIL held_reset_valid: got %b expected 0", KeyValid); end
    checks++; if (KeyCode !== 4'h0) begin errors++; $display("FAIL held_reset_code: got %h expected 0", KeyCode); end
    reset = 1'b0;
    for (int k = 0; k < 8; k++) begin
      exp_col = col_of(k / 4);
      checks++;
      if (Col !== exp_col) begin errors++; $display("FAIL held_restart_col step %0d: got %b expected %b", k, Col, exp_col); end
      tick(1);
    end

    reset = 1'b1;
    press(2'd0, 2'd2);
    tick(2);
    reset = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      tick(1);
      if (i == 19) begin
        checks++; if (Col !== 4'b1011) begin errors++; $display("FAIL deb_reset_setup_col: got %b expected 1011", Col); end
        reset = 1'b1;
      end
    end
    checks++; if (KeyValid !== 1'b0) begin errors++; $display("FAIL deb_reset_valid: got %b expected 0", KeyValid); end
    checks++; if (Value !== 32'h0) begin errors++; $display("FAIL deb_reset_value: got %h expected 0", Value); end
    checks++; if (Col !== 4'b1110) begin errors++; $display("FAIL deb_reset_col: got %b expected 1110", Col); end
    checks++; if (KeyCode !== 4'h0) begin errors++; $display("FAIL deb_reset_code: got %h expected 0", KeyCode); end
    key_on = 1'b0;
    reset = 1'b0;
    tick(4);
    checks++; if (Col !== 4'b1101) begin errors++; $display("FAIL deb_restart_col: got %b expected 1101", Col); end
    checks++; if (KeyValid !== 1'b0) begin errors++; $display("FAIL deb_restart_valid: got %b expected 0", KeyValid); end
  endtask

  initial begin
    checks = 0; errors = 0; pulses = 0;
    reset = 1'b1; Clear = 1'b0;
    key_on = 1'b0; key2_on = 1'b0;
    key_r = 2'd0; key2_r = 2'd0; key_c = 2'd0;
    test_reset();
    test_single_key();
    test_sequence();
    test_bounce();
    test_multi_and_clear();
    test_reset_midflight();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
